// File: rtl/toom_8_recomposition.sv
// Toom-8 product recomposition: accumulates 15 streamed coefficients into a 2048-bit
// product with a serial carry chain, then presents the product on a valid/ready port.
module toom_8_recomposition #(
    parameter int unsigned CHUNK_W  = 128,
    parameter int unsigned NUM_COEF = 15,
    parameter int unsigned COEF_W   = 264
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [COEF_W-1:0]               coef_in,
    input  logic                            coef_valid,
    output logic                            coef_ready,
    output logic [CHUNK_W*(NUM_COEF+1)-1:0] p_out,
    output logic                            p_valid,
    input  logic                            p_ready,
    output logic                            ovf
);
    localparam int unsigned CarryW = COEF_W + 1 - CHUNK_W;
    localparam int unsigned IdxW   = $clog2(NUM_COEF + 1);
    localparam int unsigned PW     = CHUNK_W * (NUM_COEF + 1);
    localparam int unsigned SumW   = COEF_W + 1;

    typedef enum logic [1:0] {
        StAccum,
        StFlush,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   idx_q;
    logic [CarryW-1:0] carry_q;
    logic [PW-1:0]     p_q;
    logic              p_valid_q;
    logic              ovf_q;
    logic              accept;
    logic              release_p;
    logic [SumW-1:0]   sum;

    // Carry is bounded below 2^CarryW, so one extra bit above the coefficient suffices.
    assign sum = SumW'(coef_in) + SumW'(carry_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StAccum;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        coef_ready = 1'b0;
        accept     = 1'b0;
        release_p  = 1'b0;
        unique case (state_q)
            StAccum: begin
                coef_ready = 1'b1;
                accept     = coef_valid;
                if (coef_valid && (idx_q == IdxW'(NUM_COEF - 1))) begin
                    state_d = StFlush;
                end
            end
            StFlush: begin
                state_d = StDone;
            end
            StDone: begin
                if (p_ready) begin
                    release_p = 1'b1;
                    state_d   = StAccum;
                end
            end
            default: begin
                state_d = StAccum;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q     <= '0;
            carry_q   <= '0;
            p_q       <= '0;
            p_valid_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            if (accept) begin
                p_q[idx_q*CHUNK_W +: CHUNK_W] <= sum[CHUNK_W-1:0];
                carry_q                       <= sum[SumW-1:CHUNK_W];
                idx_q                         <= idx_q + 1'b1;
            end
            if (state_q == StFlush) begin
                p_q[PW-1 -: CHUNK_W] <= carry_q[CHUNK_W-1:0];
                ovf_q                <= |carry_q[CarryW-1:CHUNK_W];
                p_valid_q            <= 1'b1;
            end
            // Product and ovf stay put after release; the next product overwrites in place.
            if (release_p) begin
                p_valid_q <= 1'b0;
                idx_q     <= '0;
                carry_q   <= '0;
            end
        end
    end

    assign p_out   = p_q;
    assign p_valid = p_valid_q;
    assign ovf     = ovf_q;

endmodule
